sd_cmd_sequencer: RTL

- Upstream command engine for the SD SPI byte-transfer interface. Accepts one SD SPI-mode command: 6-bit index, 32-bit argument, expected trailing response length.
- Emits the 6-byte frame with computed CRC7, polls for the R1 token, then collects up to 4 trailing response bytes (R3/R7).
- Drives the byte engine's start/tx-byte/busy/rx-byte handshake, so firmware no longer bit-bangs command frames through the data register. Chip select remains firmware-owned.

---
 rtl/sd_pkg.sv | 37 +++
 rtl/sd_crc7.sv | 23 ++
 rtl/sd_cmd_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI command sequencer.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_POLL,
    ST_RESP,
    ST_DONE
  } sd_state_e;

  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT_HI,
    PH_WAIT_LO
  } sd_phase_e;

  localparam logic [6:0]  CRC7_POLY          = 7'h09;
  localparam logic [7:0]  SD_FILL_BYTE       = 8'hFF;
  localparam int unsigned R1_ILLEGAL_CMD_BIT = 2;
  localparam int unsigned MAX_RESP_BYTES     = 4;

  // MSB-first CRC7 update over one byte.
  function automatic logic [6:0] crc7_update(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[6] ^ data[7 - i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Registered bytewise CRC7 accumulator for SD command frames.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)    r_crc <= '0;
    else if (i_clear)  r_crc <= '0;
    else if (i_enable) r_crc <= crc7_update(r_crc, i_data);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD SPI-mode command engine: sends a CRC7-protected frame, polls for R1,
// then gathers trailing response bytes through the byte-transfer engine.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned R1_POLL_MAX  = 8,
  parameter int unsigned PRE_FF_BYTES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [5:0]  i_cmd_index,
  input  logic [31:0] i_cmd_arg,
  input  logic [2:0]  i_resp_len,
  output logic        o_done,
  output logic        o_timeout,
  output logic [7:0]  o_r1,
  output logic [31:0] o_resp_data,
  output logic        o_spi_start,
  output logic [7:0]  o_spi_tx_data,
  input  logic        i_spi_busy,
  input  logic [7:0]  i_spi_rx_data
);

  localparam logic [2:0] LP_PRE_LAST = 3'(PRE_FF_BYTES - 1);
  localparam logic [2:0] LP_MAX_RESP = 3'(MAX_RESP_BYTES);
  localparam logic [7:0] LP_POLL_MAX = 8'(R1_POLL_MAX);

  sd_state_e   r_state, w_state_nx;
  sd_phase_e   r_phase, w_phase_nx;
  logic [2:0]  r_byte_cnt;
  logic [7:0]  r_poll_cnt;
  logic [5:0]  r_index;
  logic [31:0] r_arg;
  logic [2:0]  r_resp_len;
  logic [7:0]  r_r1;
  logic [31:0] r_resp_data;
  logic        r_timeout;

  logic        w_accept, w_xfer, w_issue, w_byte_done;
  logic [7:0]  w_poll_inc;
  logic        w_r1_seen, w_poll_expired, w_skip_resp, w_pre_last, w_resp_last;
  logic [7:0]  w_tx_byte;
  logic [6:0]  w_crc;
  logic        w_crc_en;

  assign w_accept       = i_cmd_valid && (r_state == ST_IDLE);
  assign w_xfer         = (r_state == ST_PRE) || (r_state == ST_CMD) ||
                          (r_state == ST_POLL) || (r_state == ST_RESP);
  assign w_issue        = w_xfer && (r_phase == PH_ISSUE);
  assign w_byte_done    = w_xfer && (r_phase == PH_WAIT_LO) && !i_spi_busy;
  assign w_poll_inc     = (r_poll_cnt == 8'hFF) ? r_poll_cnt : r_poll_cnt + 8'd1;
  assign w_r1_seen      = !i_spi_rx_data[7];
  assign w_poll_expired = (w_poll_inc == LP_POLL_MAX);
  assign w_skip_resp    = (r_resp_len == 3'd0) || i_spi_rx_data[R1_ILLEGAL_CMD_BIT];
  assign w_pre_last     = (r_byte_cnt == LP_PRE_LAST);
  assign w_resp_last    = (r_byte_cnt == r_resp_len - 3'd1);
  assign w_crc_en       = w_issue && (r_state == ST_CMD) && (r_byte_cnt < 3'd5);

  always_comb begin
    w_tx_byte = SD_FILL_BYTE;
    if (r_state == ST_CMD) begin
      case (r_byte_cnt)
        3'd0:    w_tx_byte = {2'b01, r_index};
        3'd1:    w_tx_byte = r_arg[31:24];
        3'd2:    w_tx_byte = r_arg[23:16];
        3'd3:    w_tx_byte = r_arg[15:8];
        3'd4:    w_tx_byte = r_arg[7:0];
        3'd5:    w_tx_byte = {w_crc, 1'b1};
        default: w_tx_byte = SD_FILL_BYTE;
      endcase
    end
  end

  sd_crc7 u_crc7 (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_accept),
    .i_enable  (w_crc_en),
    .i_data    (w_tx_byte),
    .o_crc     (w_crc)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_phase <= PH_ISSUE;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx = (PRE_FF_BYTES == 0) ? ST_CMD : ST_PRE;
          w_phase_nx = PH_ISSUE;
        end
      end
      ST_PRE, ST_CMD, ST_POLL, ST_RESP: begin
        case (r_phase)
          PH_ISSUE:   w_phase_nx = PH_WAIT_HI;
          PH_WAIT_HI: if (i_spi_busy) w_phase_nx = PH_WAIT_LO;
          PH_WAIT_LO: begin
            if (!i_spi_busy) begin
              w_phase_nx = PH_ISSUE;
              case (r_state)
                ST_PRE:  if (w_pre_last) w_state_nx = ST_CMD;
                ST_CMD:  if (r_byte_cnt == 3'd5) w_state_nx = ST_POLL;
                ST_POLL: begin
                  if (w_r1_seen)           w_state_nx = w_skip_resp ? ST_DONE : ST_RESP;
                  else if (w_poll_expired) w_state_nx = ST_DONE;
                end
                ST_RESP: if (w_resp_last) w_state_nx = ST_DONE;
                default: w_state_nx = r_state;
              endcase
            end
          end
          default: w_phase_nx = PH_ISSUE;
        endcase
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_byte_cnt  <= '0;
      r_poll_cnt  <= '0;
      r_index     <= '0;
      r_arg       <= '0;
      r_resp_len  <= '0;
      r_r1        <= '1;
      r_resp_data <= '0;
      r_timeout   <= 1'b0;
    end else if (w_accept) begin
      r_index     <= i_cmd_index;
      r_arg       <= i_cmd_arg;
      r_resp_len  <= (i_resp_len > LP_MAX_RESP) ? LP_MAX_RESP : i_resp_len;
      r_resp_data <= '0;
      r_timeout   <= 1'b0;
      r_byte_cnt  <= '0;
      r_poll_cnt  <= '0;
    end else if (w_byte_done) begin
      case (r_state)
        ST_PRE: r_byte_cnt <= w_pre_last ? 3'd0 : r_byte_cnt + 3'd1;
        ST_CMD: r_byte_cnt <= (r_byte_cnt == 3'd5) ? 3'd0 : r_byte_cnt + 3'd1;
        ST_POLL: begin
          r_poll_cnt <= w_poll_inc;
          r_byte_cnt <= '0;
          if (w_r1_seen) begin
            r_r1 <= i_spi_rx_data;
          end else if (w_poll_expired) begin
            r_r1      <= '1;
            r_timeout <= 1'b1;
          end
        end
        ST_RESP: begin
          r_resp_data <= {r_resp_data[23:0], i_spi_rx_data};
          r_byte_cnt  <= w_resp_last ? 3'd0 : r_byte_cnt + 3'd1;
        end
        default: r_byte_cnt <= r_byte_cnt;
      endcase
    end
  end

  assign o_cmd_ready   = (r_state == ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_timeout     = r_timeout;
  assign o_r1          = r_r1;
  assign o_resp_data   = r_resp_data;
  assign o_spi_start   = w_issue;
  assign o_spi_tx_data = w_issue ? w_tx_byte : SD_FILL_BYTE;

endmodule
